// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the RV32 core datapath.
// Drives pc/ir/rf write enables, the imem fetch handshake, run/halt control and a sticky fault state.
module core_sequencer #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             halt_req_i,
  input  logic             imem_valid_i,
  input  logic             dec_w_en_i,
  input  logic             dec_illegal_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int unsigned       TCNT_W    = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  state_e             state_q,     state_d;
  logic               halt_pend_q, halt_pend_d;
  logic [TCNT_W-1:0]  tcnt_q,      tcnt_d;
  logic [CNT_W-1:0]   instret_q,   instret_d;

  // State and bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      halt_pend_q <= 1'b0;
      tcnt_q      <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      tcnt_q      <= tcnt_d;
      instret_q   <= instret_d;
    end
  end

  // Next-state and enable decode; ir_we/rf_we also follow their handshake inputs
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    tcnt_d      = tcnt_q;
    instret_d   = instret_q;
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    rf_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    busy_o      = 1'b0;
    fault_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        busy_o     = 1'b1;
        if (halt_req_i) halt_pend_d = 1'b1;
        // A valid word on the last allowed cycle still beats the timeout
        if (imem_valid_i) begin
          ir_we_o = 1'b1;
          tcnt_d  = '0;
          state_d = S_DECODE;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_DECODE: begin
        busy_o = 1'b1;
        if (halt_req_i) halt_pend_d = 1'b1;
        state_d = dec_illegal_i ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        busy_o = 1'b1;
        if (halt_req_i) halt_pend_d = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        busy_o    = 1'b1;
        pc_we_o   = 1'b1;
        rf_we_o   = dec_w_en_i;
        instret_d = instret_q + CNT_W'(1);
        if (halt_pend_q || halt_req_i) begin
          halt_pend_d = 1'b0;
          state_d     = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign state_o   = 3'(state_q);
  assign instret_o = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a cycle model pushes expected outputs, sampled DUT outputs pop them.
module tb_core_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned FT    = 16;

  logic             clk, rst_n;
  logic             run, halt_req, imem_valid, dec_w_en, dec_illegal;
  logic             imem_req, ir_we, rf_we, pc_we, busy, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  core_sequencer #(.CNT_W(CNT_W), .FETCH_TIMEOUT(FT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .run_i        (run),
    .halt_req_i   (halt_req),
    .imem_valid_i (imem_valid),
    .dec_w_en_i   (dec_w_en),
    .dec_illegal_i(dec_illegal),
    .imem_req_o   (imem_req),
    .ir_we_o      (ir_we),
    .rf_we_o      (rf_we),
    .pc_we_o      (pc_we),
    .busy_o       (busy),
    .fault_o      (fault),
    .state_o      (state),
    .instret_o    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       st;
    logic             req;
    logic             ir;
    logic             rf;
    logic             pc;
    logic             bsy;
    logic             flt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int n_pc, n_rf, n_ir, n_fetch, n_fault;

  int               m_st;
  logic             m_hp;
  int               m_tcnt;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_cnt();
    n_pc = 0; n_rf = 0; n_ir = 0; n_fetch = 0; n_fault = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st  = 3'(m_st);
    e.req = (m_st == 1);
    e.ir  = (m_st == 1) && imem_valid;
    e.rf  = (m_st == 4) && dec_w_en;
    e.pc  = (m_st == 4);
    e.bsy = (m_st >= 1) && (m_st <= 4);
    e.flt = (m_st == 6);
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic model_step();
    if (m_st >= 1 && m_st <= 3 && halt_req) m_hp = 1'b1;
    case (m_st)
      0: if (run) m_st = 1;
      1: begin
        if (imem_valid) begin m_tcnt = 0; m_st = 2; end
        else if (m_tcnt == FT - 1) m_st = 6;
        else m_tcnt++;
      end
      2: m_st = dec_illegal ? 6 : 3;
      3: m_st = 4;
      4: begin
        m_cnt = CNT_W'(m_cnt + 1);
        if (m_hp || halt_req) begin m_st = 5; m_hp = 1'b0; end
        else m_st = 1;
      end
      5: if (run) m_st = 1;
      default: m_st = 6;
    endcase
  endtask

  // One clock: push expectation, compare at negedge, advance model at posedge
  task automatic cycle();
    exp_t e;
    sb_q.push_back(model_out());
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("state",    32'(state),    32'(e.st));
      check_val("imem_req", 32'(imem_req), 32'(e.req));
      check_val("ir_we",    32'(ir_we),    32'(e.ir));
      check_val("rf_we",    32'(rf_we),    32'(e.rf));
      check_val("pc_we",    32'(pc_we),    32'(e.pc));
      check_val("busy",     32'(busy),     32'(e.bsy));
      check_val("fault",    32'(fault),    32'(e.flt));
      check_val("instret",  32'(instret),  32'(e.cnt));
    end
    n_pc    += int'(pc_we);
    n_rf    += int'(rf_we);
    n_ir    += int'(ir_we);
    n_fetch += int'(state == 3'd1);
    n_fault += int'(fault);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; halt_req = 1'b0; imem_valid = 1'b0; dec_w_en = 1'b0; dec_illegal = 1'b0;
    rst_n = 1'b0;
    m_st = 0; m_hp = 1'b0; m_tcnt = 0; m_cnt = '0;
    #1;
    check_val("rst_state",   32'(state),   32'd0);
    check_val("rst_instret", 32'(instret), 32'd0);
    check_val("rst_outs",    32'({imem_req, ir_we, rf_we, pc_we, busy, fault}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cnt();
    do_reset();

    // Back-to-back instructions with a always-ready memory
    run = 1'b1; imem_valid = 1'b1; dec_w_en = 1'b1;
    clear_cnt();
    repeat (13) cycle();
    check_val("loop_pc_we_cnt", 32'(n_pc), 32'd3);
    check_val("loop_ir_we_cnt", 32'(n_ir), 32'd3);
    check_val("loop_instret",   32'(instret), 32'd3);

    // Five wait cycles then valid
    imem_valid = 1'b0; clear_cnt();
    repeat (5) cycle();
    imem_valid = 1'b1;
    cycle();
    check_val("wait_fetch_cycles", 32'(n_fetch), 32'd6);
    check_val("wait_ir_we_cnt",    32'(n_ir),    32'd1);
    check_val("wait_state",        32'(state),   32'd2);
    repeat (3) cycle();
    check_val("wait_instret", 32'(instret), 32'd4);

    // Valid arrives on the last allowed fetch cycle
    imem_valid = 1'b0; clear_cnt();
    repeat (FT - 1) cycle();
    imem_valid = 1'b1;
    cycle();
    check_val("edge_fetch_cycles", 32'(n_fetch), 32'd16);
    check_val("edge_state",        32'(state),   32'd2);
    check_val("edge_fault",        32'(fault),   32'd0);
    repeat (3) cycle();
    check_val("edge_instret", 32'(instret), 32'd5);

    // Fetch timeout and sticky fault
    imem_valid = 1'b0; clear_cnt();
    repeat (FT - 1) cycle();
    check_val("to_pre_fault", 32'(fault), 32'd0);
    cycle();
    check_val("to_fault",        32'(fault),   32'd1);
    check_val("to_state",        32'(state),   32'd6);
    check_val("to_fetch_cycles", 32'(n_fetch), 32'd16);
    clear_cnt();
    for (int i = 0; i < 6; i++) begin
      run = (i % 2 == 0);
      imem_valid = (i % 3 == 0);
      cycle();
    end
    check_val("sticky_fault_cycles", 32'(n_fault), 32'd6);
    check_val("sticky_instret",      32'(instret), 32'd5);

    // halt_req pulse during DECODE
    do_reset();
    run = 1'b1; imem_valid = 1'b1; dec_w_en = 1'b1;
    repeat (2) cycle();
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0; run = 1'b0;
    cycle();
    clear_cnt();
    cycle();
    check_val("halt_pc_we",   32'(n_pc),    32'd1);
    check_val("halt_state",   32'(state),   32'd5);
    check_val("halt_instret", 32'(instret), 32'd1);
    repeat (2) cycle();
    halt_req = 1'b1;
    cycle();
    check_val("halt_ignore_req", 32'(state), 32'd5);
    run = 1'b1;
    cycle();
    halt_req = 1'b0;
    check_val("halt_resume", 32'(state), 32'd1);
    repeat (4) cycle();
    check_val("halt_no_pending", 32'(state),   32'd1);
    check_val("halt_instret2",   32'(instret), 32'd2);

    // Illegal opcode faults from DECODE without writes
    cycle();
    dec_illegal = 1'b1; clear_cnt();
    cycle();
    dec_illegal = 1'b0;
    repeat (3) cycle();
    check_val("ill_state",    32'(state),   32'd6);
    check_val("ill_pc_we",    32'(n_pc),    32'd0);
    check_val("ill_rf_we",    32'(n_rf),    32'd0);
    check_val("ill_instret",  32'(instret), 32'd2);
    check_val("ill_fault_cy", 32'(n_fault), 32'd3);

    // dec_w_en gating in WB
    do_reset();
    run = 1'b1; imem_valid = 1'b1; dec_w_en = 1'b0;
    repeat (4) cycle();
    clear_cnt();
    cycle();
    check_val("nowen_pc_we", 32'(n_pc), 32'd1);
    check_val("nowen_rf_we", 32'(n_rf), 32'd0);
    dec_w_en = 1'b1; clear_cnt();
    repeat (4) cycle();
    check_val("wen_rf_we",   32'(n_rf),    32'd1);
    check_val("wen_instret", 32'(instret), 32'd2);

    // Reset while in EXEC
    repeat (2) cycle();
    check_val("pre_rst_exec", 32'(state), 32'd3);
    do_reset();

    // Counter wrap with a 4-bit instret
    run = 1'b1; imem_valid = 1'b1; dec_w_en = 1'b1;
    cycle();
    repeat (60) cycle();
    check_val("wrap_15", 32'(instret), 32'd15);
    repeat (4) cycle();
    check_val("wrap_0",     32'(instret), 32'd0);
    check_val("wrap_state", 32'(state),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
